mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the core's instruction-fetch port (I, read-only)
//  and its load/store port (D, read/write). Sits between top_proc and the memory model.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between an instruction-fetch port and a load/store port.
// Optional per-access timeout is compiled in with `define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("TIMEOUT must be at least 1");
    end

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;   // 1 when the most recent grant went to D
    logic              gnt_d_q, gnt_d_d;     // 1 when the access in flight belongs to D
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              pick_d;
    logic              timed_out;
    logic [DATA_W-1:0] resp_data;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        gnt_d_d     = gnt_d_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = i_ack_q;
        d_ack_d     = d_ack_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;
        pick_d      = 1'b0;
        timed_out   = 1'b0;
        resp_data   = mem_rdata;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // On a conflict the port that did not win last time is served.
                    pick_d      = d_req && (!i_req || !last_d_q);
                    gnt_d_d     = pick_d;
                    last_d_d    = pick_d;
                    mem_req_d   = 1'b1;
                    mem_we_d    = pick_d && d_we;
                    mem_addr_d  = pick_d ? d_addr : i_addr;
                    mem_wdata_d = pick_d ? d_wdata : '0;
                    state_d     = ISSUE;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ISSUE: begin
`ifdef ARB_TIMEOUT_EN
                timed_out = !mem_ack && (cnt_q == CNT_LAST);
                if (!mem_ack && !timed_out) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
                if (mem_ack || timed_out) begin
                    resp_data = timed_out ? '0 : mem_rdata;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = timed_out;
                    state_d   = RESP;
                    if (gnt_d_q) begin
                        d_ack_d = 1'b1;
                        // A completed store leaves the load-data register alone.
                        if (!mem_we_q || timed_out) begin
                            d_rdata_d = resp_data;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = resp_data;
                    end
                end
            end
            RESP: begin
                i_ack_d = 1'b0;
                d_ack_d = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            gnt_d_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            gnt_d_q     <= gnt_d_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign i_ack     = i_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level model of the arbiter and memory.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam logic [31:0] I_A  = 32'h0040_0000;
    localparam logic [31:0] D_A  = 32'h1001_0000;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we, mem_ack;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          i_ack, d_ack, mem_req, mem_we, busy, err;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .err(err)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, i, d, ack;
        logic [31:0] rdata;
        logic [5:0]  ctl;      // {mem_req, mem_we, i_ack, d_ack, busy, err}
        logic [31:0] addr, ir, dr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic i, input logic d, input logic a,
                                input logic [31:0] rd, input logic [5:0] c,
                                input logic [31:0] ad, input logic [31:0] ir, input logic [31:0] dr);
        vec_t v;
        v.rst = r; v.i = i; v.d = d; v.ack = a; v.rdata = rd;
        v.ctl = c; v.addr = ad; v.ir = ir; v.dr = dr;
        return v;
    endfunction

    // Behavioural memory: unwritten words read back as a hash of their address.
    logic [31:0] mem_m [logic [31:0]];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : (a ^ 32'hA5A5_5A5A);
    endfunction

    vec_t tbl [18];

    initial begin
        logic [5:0] S_IDLE, S_ISS, S_IR, S_DR;
        logic [31:0] RD1, RD2, RD3, RD4, RD5;
        // random-phase model state
        bit          i_pend, d_pend, rd_we, allow;
        logic [31:0] ri_addr, rd_addr, rd_wdata;
        int          phase, port, last, lat, i_start, d_start, max_wait, acks_dut, done_model;
        logic        exp_we;
        logic [31:0] exp_addr, exp_wdata, exp_ir, exp_dr;

        S_IDLE = 6'b000000; S_ISS = 6'b100010; S_IR = 6'b001010; S_DR = 6'b000110;
        RD1 = 32'h0050_0113; RD2 = 32'h1111_1111; RD3 = 32'h2222_2222;
        RD4 = 32'h3333_3333; RD5 = 32'h4444_4444;

        tbl[0]  = mk(1, 1, 1, 0, JUNK, S_IDLE, 0,   0,   0);
        tbl[1]  = mk(1, 1, 1, 0, JUNK, S_IDLE, 0,   0,   0);
        tbl[2]  = mk(0, 1, 0, 0, JUNK, S_ISS,  I_A, 0,   0);
        tbl[3]  = mk(0, 1, 0, 1, RD1,  S_IR,   I_A, RD1, 0);
        tbl[4]  = mk(0, 0, 0, 0, JUNK, S_IDLE, I_A, RD1, 0);
        tbl[5]  = mk(1, 0, 0, 0, JUNK, S_IDLE, 0,   0,   0);
        tbl[6]  = mk(0, 1, 1, 0, JUNK, S_ISS,  D_A, 0,   0);
        tbl[7]  = mk(0, 1, 1, 1, RD2,  S_DR,   D_A, 0,   RD2);
        tbl[8]  = mk(0, 1, 0, 1, JUNK, S_IDLE, D_A, 0,   RD2);
        tbl[9]  = mk(0, 1, 0, 0, JUNK, S_ISS,  I_A, 0,   RD2);
        tbl[10] = mk(0, 1, 0, 1, RD3,  S_IR,   I_A, RD3, RD2);
        tbl[11] = mk(0, 1, 1, 0, JUNK, S_IDLE, I_A, RD3, RD2);
        tbl[12] = mk(0, 1, 1, 0, JUNK, S_ISS,  D_A, RD3, RD2);
        tbl[13] = mk(0, 1, 1, 1, RD4,  S_DR,   D_A, RD3, RD4);
        tbl[14] = mk(0, 1, 0, 0, JUNK, S_IDLE, D_A, RD3, RD4);
        tbl[15] = mk(0, 1, 0, 0, JUNK, S_ISS,  I_A, RD3, RD4);
        tbl[16] = mk(0, 1, 0, 1, RD5,  S_IR,   I_A, RD5, RD4);
        tbl[17] = mk(0, 0, 0, 0, JUNK, S_IDLE, I_A, RD5, RD4);

        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        i_addr = I_A; d_addr = D_A; d_wdata = 32'h0; mem_rdata = JUNK;
        @(negedge clk);

        // Directed table: reset, fetch, conflicts, ignored acks and requests in RESP
        for (int k = 0; k < 18; k++) begin
            rst = tbl[k].rst; i_req = tbl[k].i; d_req = tbl[k].d; d_we = 1'b0;
            mem_ack = tbl[k].ack; mem_rdata = tbl[k].rdata;
            @(negedge clk);
            check($sformatf("table_row%0d", k),
                  {mem_req, mem_we, i_ack, d_ack, busy, err, mem_addr, i_rdata, d_rdata},
                  {tbl[k].ctl, tbl[k].addr, tbl[k].ir, tbl[k].dr});
        end
        i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;

        // Store with three wait states
        d_req = 1'b1; d_we = 1'b1; d_addr = D_A; d_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("store_issue", {mem_req, mem_we, d_ack, mem_addr, mem_wdata},
                  {1'b1, 1'b1, 1'b0, D_A, 32'hDEAD_BEEF});
            if (c == 3) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; end
        end
        @(negedge clk);
        check("store_ack", {mem_req, mem_we, i_ack, d_ack, d_rdata}, {4'b0001, RD4});
        d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        check("store_ack_single", {d_ack, busy}, 2'b00);

        // Reset during a load's wait
        d_req = 1'b1; d_addr = D_A + 32'h4;
        @(negedge clk);
        check("rst_mid_issue_pre", mem_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_issue", {mem_req, d_ack, busy}, 3'b000);
        rst = 1'b0; d_req = 1'b0; mem_ack = 1'b1; mem_rdata = JUNK;
        @(negedge clk);
        check("ack_after_rst", {mem_req, i_ack, d_ack, busy, d_rdata}, {4'b0000, 32'h0});
        mem_ack = 1'b0;

        // Randomized traffic against a transaction-level model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_pend = 0; d_pend = 0; rd_we = 0; phase = 0; port = 0; last = 0; lat = 0;
        i_start = 0; d_start = 0; max_wait = 0; acks_dut = 0; done_model = 0;
        exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_ir = 0; exp_dr = 0;
        ri_addr = 0; rd_addr = 0; rd_wdata = 0;
        for (int cyc = 0; cyc < 1540; cyc++) begin
            allow = (cyc < 1500);
            @(negedge clk);
            if (i_ack) acks_dut++;
            if (d_ack) acks_dut++;
            case (phase)
                0: check("rnd_idle", {mem_req, i_ack, d_ack, busy, err}, 5'b00000);
                1: check("rnd_issue", {mem_req, mem_we, i_ack, d_ack, busy, err, mem_addr, mem_wdata},
                         {1'b1, exp_we, 4'b0010, exp_addr, exp_wdata});
                default: begin
                    check("rnd_resp", {mem_req, mem_we, i_ack, d_ack, busy, err, i_rdata, d_rdata},
                          {2'b00, port == 0, port == 1, 2'b10, exp_ir, exp_dr});
                    done_model++;
                    if (port == 0) begin
                        i_pend = 0;
                        if (cyc - i_start > max_wait) max_wait = cyc - i_start;
                    end else begin
                        d_pend = 0;
                        if (cyc - d_start > max_wait) max_wait = cyc - d_start;
                    end
                end
            endcase
            if (allow && !i_pend && !(phase == 2 && port == 0) && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_start = cyc;
                ri_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (allow && !d_pend && !(phase == 2 && port == 1) && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_start = cyc;
                rd_addr = 32'($urandom_range(0, 15)) << 2;
                rd_we = $urandom_range(0, 1) == 1;
                rd_wdata = $urandom;
            end
            i_req = i_pend; i_addr = ri_addr;
            d_req = d_pend; d_addr = rd_addr; d_we = rd_we; d_wdata = rd_wdata;
            mem_ack = 1'b0; mem_rdata = $urandom;
            case (phase)
                0: begin
                    if (i_pend || d_pend) begin
                        if (i_pend && d_pend) port = (last == 0) ? 1 : 0;
                        else port = d_pend ? 1 : 0;
                        last = port;
                        exp_addr  = port == 1 ? rd_addr : ri_addr;
                        exp_we    = port == 1 ? rd_we : 1'b0;
                        exp_wdata = port == 1 ? rd_wdata : 32'h0;
                        lat = $urandom_range(0, 3);
                        phase = 1;
                    end else if ($urandom_range(0, 3) == 0) begin
                        mem_ack = 1'b1;
                    end
                end
                1: begin
                    if (lat == 0) begin
                        mem_ack = 1'b1;
                        mem_rdata = mem_rd(mem_addr);
                        if (port == 0) exp_ir = mem_rd(ri_addr);
                        else if (!rd_we) exp_dr = mem_rd(rd_addr);
                        if (mem_we) mem_m[mem_addr] = mem_wdata;
                        phase = 2;
                    end else begin
                        lat--;
                    end
                end
                default: begin
                    phase = 0;
                    if ($urandom_range(0, 1) == 0) mem_ack = 1'b1;
                end
            endcase
        end
        check("rnd_ack_count", 128'(acks_dut), 128'(done_model));
        check("rnd_no_starvation", {127'h0, max_wait <= 20}, 128'h1);
        check("rnd_drained", 128'(phase), 128'h0);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Load that memory never acknowledges
        d_req = 1'b1; d_addr = D_A;
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            check("timeout_wait", {mem_req, d_ack, err}, 3'b100);
        end
        @(negedge clk);
        check("timeout_resp", {mem_req, d_ack, err, d_rdata}, {3'b011, 32'h0});
        d_req = 1'b0;
        @(negedge clk);
        check("timeout_after", {d_ack, err, busy}, 3'b000);
`else
        // Without the timeout, a long memory stall is simply waited out
        d_req = 1'b1; d_addr = D_A;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("long_wait", {mem_req, d_ack, err}, 3'b100);
            if (c == 19) begin mem_ack = 1'b1; mem_rdata = 32'h5A5A_1234; end
        end
        @(negedge clk);
        check("long_wait_resp", {mem_req, d_ack, err, d_rdata}, {3'b010, 32'h5A5A_1234});
        d_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        check("long_wait_after", {d_ack, err, busy}, 3'b000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
